// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between WB and a queued long-latency unit,
// with an anti-starvation override and a busy scoreboard. Optional: REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wbValid,
  input  logic [4:0]            wbRd,
  input  logic [DATA_WIDTH-1:0] wbData,
  output logic                  wbStall,
  input  logic                  lluValid,
  output logic                  lluReady,
  input  logic [4:0]            lluRd,
  input  logic [DATA_WIDTH-1:0] lluData,
  input  logic                  issueValid,
  input  logic [4:0]            issueRd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  output logic                  rs1Busy,
  output logic                  rs2Busy,
  output logic [4:0]            rfRd,
  output logic [DATA_WIDTH-1:0] rfWriteData,
  output logic                  rfRegisterWrite
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
  logic [4:0]            fifo_rd_r   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [SW-1:0]         starve_r;
  logic [31:0]           scoreboard_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  llu_xfer_s;
  logic                  wb_req_s;
  logic                  starved_s;
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  stall_s;
  logic                  rf_we_s;
  logic [4:0]            rf_rd_s;
  logic [DATA_WIDTH-1:0] rf_data_s;
  logic                  llu_wr_s;
  logic [4:0]            llu_wr_rd_s;
  logic [31:0]           set_mask_s;
  logic [31:0]           clr_mask_s;
  logic [31:0]           scoreboard_next_s;

  // Handshake and queue control decoded from current state and requests.
  always_comb begin
    full_s     = (count_r == FULL_COUNT);
    empty_s    = (count_r == {CW{1'b0}});
    llu_xfer_s = lluValid & ~full_s & ~reset;
    wb_req_s   = wbValid & (wbRd != 5'd0);
    starved_s  = (starve_r == STARVE_MAX) & ~empty_s;
`ifdef REGFILE_ARB_BYPASS_EN
    bypass_s   = llu_xfer_s & empty_s & ~wb_req_s & (lluRd != 5'd0);
`else
    bypass_s   = 1'b0;
`endif
    push_s     = llu_xfer_s & (lluRd != 5'd0) & ~bypass_s;
    pop_s      = ~reset & ~empty_s & (starved_s | ~wb_req_s);
  end

  // Write-port grant: starved LLU head, then WB, then queued LLU, then bypass.
  always_comb begin
    stall_s     = 1'b0;
    rf_we_s     = 1'b0;
    rf_rd_s     = 5'd0;
    rf_data_s   = {DATA_WIDTH{1'b0}};
    llu_wr_s    = 1'b0;
    llu_wr_rd_s = 5'd0;
    if (reset) begin
      stall_s = 1'b0;
    end else if (starved_s) begin
      stall_s     = 1'b1;
      rf_we_s     = 1'b1;
      rf_rd_s     = fifo_rd_r[rd_ptr_r];
      rf_data_s   = fifo_data_r[rd_ptr_r];
      llu_wr_s    = 1'b1;
      llu_wr_rd_s = fifo_rd_r[rd_ptr_r];
    end else if (wb_req_s) begin
      rf_we_s   = 1'b1;
      rf_rd_s   = wbRd;
      rf_data_s = wbData;
    end else if (~empty_s) begin
      rf_we_s     = 1'b1;
      rf_rd_s     = fifo_rd_r[rd_ptr_r];
      rf_data_s   = fifo_data_r[rd_ptr_r];
      llu_wr_s    = 1'b1;
      llu_wr_rd_s = fifo_rd_r[rd_ptr_r];
    end else if (bypass_s) begin
      rf_we_s     = 1'b1;
      rf_rd_s     = lluRd;
      rf_data_s   = lluData;
      llu_wr_s    = 1'b1;
      llu_wr_rd_s = lluRd;
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Dropped transfers only ever carry rd 0, so they never clear a scoreboard bit.
  always_comb begin
    set_mask_s = (issueValid & (issueRd != 5'd0)) ? (32'd1 << issueRd) : 32'd0;
    clr_mask_s = (llu_wr_s & (llu_wr_rd_s != 5'd0)) ? (32'd1 << llu_wr_rd_s) : 32'd0;
    scoreboard_next_s = ((scoreboard_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  assign wbStall         = stall_s;
  assign lluReady        = ~full_s & ~reset;
  assign rfRegisterWrite = rf_we_s;
  assign rfRd            = rf_rd_s;
  assign rfWriteData     = rf_data_s;
  assign rs1Busy         = scoreboard_r[rs1] & ~reset;
  assign rs2Busy         = scoreboard_r[rs2] & ~reset;

  // LLU result queue storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_rd_r[i]   <= 5'd0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= lluData;
        fifo_rd_r[wr_ptr_r]   <= lluRd;
        wr_ptr_r              <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter and scoreboard state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_r     <= {SW{1'b0}};
      scoreboard_r <= 32'd0;
    end else begin
      if (pop_s) begin
        starve_r <= {SW{1'b0}};
      end else if (~empty_s && (starve_r != STARVE_MAX)) begin
        starve_r <= starve_r + SW'(1);
      end else begin
        starve_r <= starve_r;
      end
      scoreboard_r <= scoreboard_next_s;
    end
  end

endmodule
